// File: rtl/timer_a_pkg.sv
// Shared constants and helpers for the Timer_A interrupt controller.
//   IV_W       : width of the TAxIV vector register
//   CCM_MAX    : largest supported number of capture/compare blocks
//   TAIV_NONE  : vector value when nothing is pending
//   TAIV_TAIFG : vector value for the overflow flag
//   ccr_iv(n)  : vector value for CCRn (n = 1..6)
package timer_a_pkg;

  localparam int unsigned IV_W    = 4;
  localparam int unsigned CCM_MAX = 7;

  typedef logic [IV_W-1:0] taiv_t;

  localparam taiv_t TAIV_NONE  = 4'd0;
  localparam taiv_t TAIV_TAIFG = 4'd14;

  // CCRn is reported as 2*n so the CPU can add TAxIV straight onto a jump table.
  function automatic taiv_t ccr_iv(input int n);
    return IV_W'(2 * n);
  endfunction

endpackage

// File: rtl/timer_a_iv_encode.sv
// Fixed-priority encoder producing the TAxIV value from the pending set.
// The lowest-numbered pending CCR wins; the overflow flag has the lowest priority.
// Ports:
//   pend   in  NPEND  pending bits for CCR1..CCR(NPEND) (bit 0 = CCR1)
//   pend_t in  1      overflow pending
//   iv_c   out IV_W   encoded vector (combinational)
module timer_a_iv_encode
  import timer_a_pkg::*;
#(
  parameter int unsigned NPEND = 6
) (
  input  logic [NPEND-1:0] pend,
  input  logic             pend_t,
  output logic [IV_W-1:0]  iv_c
);

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    iv_c = pend_t ? TAIV_TAIFG : TAIV_NONE;
    for (int i = int'(NPEND) - 1; i >= 0; i--) begin
      if (pend[i]) iv_c = ccr_iv(i + 1);
    end
  end

endmodule

// File: rtl/timer_a_int_ctrl.sv
// Timer_A interrupt controller: merges CCIFG/TAIFG flags with their enables into the
// INT0 (CCR0) and INT1 (CCR1..n, overflow) requests, holds the TAxIV vector register
// and issues flag-clear pulses for TAxIV reads and the CCR0 acknowledge.
// Build option:
//   TIMERA_INT_REG_EN defined   -> TAxINT0/TAxINT1 registered (1-cycle latency, reset 0)
//   TIMERA_INT_REG_EN undefined -> TAxINT0/TAxINT1 combinational
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   wTAIFG, wTAIE overflow flag and enable
//   wCCIFG, wCCIE capture/compare flags and enables (bit n = CCRn)
//   TAxIVread     CPU reads TAxIV this cycle
//   TAxCLR0       CPU acknowledges the INT0 vector this cycle
//   TAxIV         registered interrupt vector
//   TAxINT1       request for CCR1..n / overflow
//   TAxINT0       request for CCR0
//   TAIFGclr      clear pulse for TAIFG
//   CCIFGclr      clear pulses for CCIFG bits
module timer_a_int_ctrl
  import timer_a_pkg::*;
#(
  parameter int unsigned CCM_COUNT = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wTAIFG,
  input  logic                 wTAIE,
  input  logic [CCM_COUNT-1:0] wCCIFG,
  input  logic [CCM_COUNT-1:0] wCCIE,
  input  logic                 TAxIVread,
  input  logic                 TAxCLR0,
  output logic [IV_W-1:0]      TAxIV,
  output logic                 TAxINT1,
  output logic                 TAxINT0,
  output logic                 TAIFGclr,
  output logic [CCM_COUNT-1:0] CCIFGclr
);

  localparam int unsigned NPEND = CCM_COUNT - 1;

  if (CCM_COUNT < 2 || CCM_COUNT > CCM_MAX) begin : g_bad_count
    $error("timer_a_int_ctrl: CCM_COUNT must be in 2..7");
  end

  logic [CCM_COUNT-1:0] pend;
  logic                 pend_t;
  logic [IV_W-1:0]      iv_q;
  logic [IV_W-1:0]      iv_next_c;
  logic [CCM_COUNT-1:0] ccifg_clr_c;
  logic                 taifg_clr_c;
  logic [NPEND-1:0]     pend_hi_masked_c;
  logic                 pend_t_masked_c;
  logic                 int0_c;
  logic                 int1_c;

  // Only enabled flags can pend.
  assign pend   = wCCIFG & wCCIE;
  assign pend_t = wTAIFG & wTAIE;

  // Clear pulses decode the registered vector, so a reset that zeroes TAxIV also kills them.
  always_comb begin
    ccifg_clr_c    = '0;
    ccifg_clr_c[0] = TAxCLR0;
    for (int n = 1; n < int'(CCM_COUNT); n++) begin
      if (TAxIVread && (iv_q == ccr_iv(n))) ccifg_clr_c[n] = 1'b1;
    end
    taifg_clr_c = TAxIVread && (iv_q == TAIV_TAIFG);
  end

  // The flag being cleared is still set at this edge, so hide it from the next vector.
  assign pend_hi_masked_c = pend[CCM_COUNT-1:1] & ~ccifg_clr_c[CCM_COUNT-1:1];
  assign pend_t_masked_c  = pend_t & ~taifg_clr_c;

  timer_a_iv_encode #(
    .NPEND (NPEND)
  ) u_iv_encode (
    .pend   (pend_hi_masked_c),
    .pend_t (pend_t_masked_c),
    .iv_c   (iv_next_c)
  );

  // Vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) iv_q <= TAIV_NONE;
    else        iv_q <= iv_next_c;
  end

  assign int0_c = pend[0];
  assign int1_c = (|pend[CCM_COUNT-1:1]) | pend_t;

`ifdef TIMERA_INT_REG_EN
  logic int0_q;
  logic int1_q;

  // Registered request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int0_q <= 1'b0;
      int1_q <= 1'b0;
    end else begin
      int0_q <= int0_c;
      int1_q <= int1_c;
    end
  end

  assign TAxINT0 = int0_q;
  assign TAxINT1 = int1_q;
`else
  assign TAxINT0 = int0_c;
  assign TAxINT1 = int1_c;
`endif

  assign TAxIV    = iv_q;
  assign CCIFGclr = ccifg_clr_c;
  assign TAIFGclr = taifg_clr_c;

endmodule

// File: tb/tb_timer_a_int_ctrl.sv
// Directed self-checking bench for timer_a_int_ctrl (CCM_COUNT = 7).
module tb_timer_a_int_ctrl;

  logic       clk;
  logic       rst_n;
  logic       taifg;
  logic       taie;
  logic [6:0] cc_if;
  logic [6:0] cc_ie;
  logic       iv_read;
  logic       clr0;
  logic [3:0] iv;
  logic       int1;
  logic       int0;
  logic       taifg_clr;
  logic [6:0] ccifg_clr;

  int passed = 0;
  int total  = 0;

  timer_a_int_ctrl #(.CCM_COUNT(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wTAIFG    (taifg),
    .wTAIE     (taie),
    .wCCIFG    (cc_if),
    .wCCIE     (cc_ie),
    .TAxIVread (iv_read),
    .TAxCLR0   (clr0),
    .TAxIV     (iv),
    .TAxINT1   (int1),
    .TAxINT0   (int0),
    .TAIFGclr  (taifg_clr),
    .CCIFGclr  (ccifg_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs were set after a falling edge, results sampled at the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; taifg = 0; taie = 0; cc_if = '0; cc_ie = '0; iv_read = 0; clr0 = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (iv !== 4'd0) $display("FAIL reset_iv: got %0d expected 0", iv); else passed++;
    total++; if (ccifg_clr !== 7'h00 || taifg_clr !== 1'b0)
      $display("FAIL reset_clr: got cc=%h t=%b expected 00/0", ccifg_clr, taifg_clr); else passed++;
    total++; if (int0 !== 1'b0 || int1 !== 1'b0)
      $display("FAIL reset_int: got int0=%b int1=%b expected 0/0", int0, int1); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_priority_fill();
    logic [3:0] exp_iv;
    cc_ie = 7'h7f; taie = 1'b1;
    step();
    total++; if (iv !== 4'd0) $display("FAIL fill_idle_iv: got %0d expected 0", iv); else passed++;
    taifg = 1'b1;
    step();
    total++; if (iv !== 4'd14) $display("FAIL fill_taifg_iv: got %0d expected 14", iv); else passed++;
    total++; if (int1 !== 1'b1 || int0 !== 1'b0)
      $display("FAIL fill_taifg_int: got int1=%b int0=%b expected 1/0", int1, int0); else passed++;
    for (int n = 6; n >= 1; n--) begin
      cc_if[n] = 1'b1;
      step();
      exp_iv = 4'(2 * n);
      total++; if (iv !== exp_iv) $display("FAIL fill_ccr%0d_iv: got %0d expected %0d", n, iv, exp_iv); else passed++;
      total++; if (int1 !== 1'b1 || int0 !== 1'b0)
        $display("FAIL fill_ccr%0d_int: got int1=%b int0=%b expected 1/0", n, int1, int0); else passed++;
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] exp_iv;
    for (int n = 1; n <= 6; n++) begin
      cc_ie[n] = 1'b0;
      step();
      exp_iv = (n < 6) ? 4'(2 * (n + 1)) : 4'd14;
      total++; if (iv !== exp_iv) $display("FAIL drop_ie%0d_iv: got %0d expected %0d", n, iv, exp_iv); else passed++;
      total++; if (int1 !== 1'b1) $display("FAIL drop_ie%0d_int1: got %b expected 1", n, int1); else passed++;
    end
    taie = 1'b0;
    step();
    total++; if (iv !== 4'd0) $display("FAIL drop_taie_iv: got %0d expected 0", iv); else passed++;
    total++; if (int1 !== 1'b0) $display("FAIL drop_taie_int1: got %b expected 0", int1); else passed++;
  endtask

  task automatic test_int0();
    cc_if = 7'h01; cc_ie = 7'h01; taifg = 0; taie = 0;
    step();
    total++; if (int0 !== 1'b1) $display("FAIL int0_on: got %b expected 1", int0); else passed++;
    total++; if (iv !== 4'd0) $display("FAIL int0_iv: got %0d expected 0", iv); else passed++;
    total++; if (int1 !== 1'b0) $display("FAIL int0_int1: got %b expected 0", int1); else passed++;
    cc_ie = 7'h00;
    step();
    total++; if (int0 !== 1'b0) $display("FAIL int0_off: got %b expected 0", int0); else passed++;
  endtask

  task automatic test_clr0();
    cc_if = '0;
    clr0 = 1'b1;
    #1;
    total++; if (ccifg_clr !== 7'b0000001 || taifg_clr !== 1'b0)
      $display("FAIL clr0_pulse: got cc=%b t=%b expected 0000001/0", ccifg_clr, taifg_clr); else passed++;
    @(negedge clk);
    clr0 = 1'b0;
    #1;
    total++; if (ccifg_clr !== 7'b0000000) $display("FAIL clr0_end: got %b expected 0000000", ccifg_clr); else passed++;
  endtask

  task automatic test_clr_both();
    cc_if = 7'h10; cc_ie = 7'h10;
    step();
    total++; if (iv !== 4'd8) $display("FAIL both_iv: got %0d expected 8", iv); else passed++;
    iv_read = 1'b1; clr0 = 1'b1;
    #1;
    total++; if (ccifg_clr !== 7'b0010001 || taifg_clr !== 1'b0)
      $display("FAIL both_pulse: got cc=%b t=%b expected 0010001/0", ccifg_clr, taifg_clr); else passed++;
    @(posedge clk);
    #1 cc_if = '0; iv_read = 1'b0; clr0 = 1'b0;
    @(negedge clk);
    total++; if (iv !== 4'd0 || ccifg_clr !== 7'h00)
      $display("FAIL both_after: got iv=%0d cc=%b expected 0/0000000", iv, ccifg_clr); else passed++;
  endtask

  task automatic test_read_drain();
    logic [3:0] exp_iv;
    logic [6:0] exp_cc;
    logic       exp_t;
    cc_if = 7'h7e; cc_ie = 7'h7e; taifg = 1'b1; taie = 1'b1;
    step();
    total++; if (iv !== 4'd2) $display("FAIL drain_start_iv: got %0d expected 2", iv); else passed++;
    iv_read = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      #1;
      exp_iv = (k == 7) ? 4'd14 : 4'(2 * k);
      exp_cc = (k == 7) ? 7'h00 : 7'(1 << k);
      exp_t  = (k == 7);
      total++; if (iv !== exp_iv) $display("FAIL drain%0d_iv: got %0d expected %0d", k, iv, exp_iv); else passed++;
      total++; if (ccifg_clr !== exp_cc || taifg_clr !== exp_t)
        $display("FAIL drain%0d_clr: got cc=%b t=%b expected %b/%b", k, ccifg_clr, taifg_clr, exp_cc, exp_t); else passed++;
      // The flag register drops the bit at the edge that registers the pulse.
      @(posedge clk);
      #1;
      if (k == 7) taifg = 1'b0; else cc_if[k] = 1'b0;
      @(negedge clk);
    end
    #1;
    total++; if (iv !== 4'd0) $display("FAIL drain_end_iv: got %0d expected 0", iv); else passed++;
    total++; if (ccifg_clr !== 7'h00 || taifg_clr !== 1'b0)
      $display("FAIL drain_end_clr: got cc=%b t=%b expected 0000000/0", ccifg_clr, taifg_clr); else passed++;
    iv_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    cc_if = 7'h08; cc_ie = 7'h08;
    step();
    total++; if (iv !== 4'd6) $display("FAIL rmr_iv: got %0d expected 6", iv); else passed++;
    iv_read = 1'b1;
    #1;
    total++; if (ccifg_clr !== 7'h08) $display("FAIL rmr_pre_clr: got %b expected 0001000", ccifg_clr); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (iv !== 4'd0) $display("FAIL rmr_iv_zero: got %0d expected 0", iv); else passed++;
    total++; if (ccifg_clr !== 7'h00 || taifg_clr !== 1'b0)
      $display("FAIL rmr_clr: got cc=%b t=%b expected 0000000/0", ccifg_clr, taifg_clr); else passed++;
    step();
    total++; if (iv !== 4'd0 || ccifg_clr !== 7'h00)
      $display("FAIL rmr_hold: got iv=%0d cc=%b expected 0/0000000", iv, ccifg_clr); else passed++;
    rst_n = 1'b1; iv_read = 1'b0; cc_if = '0;
    step();
    total++; if (iv !== 4'd0) $display("FAIL rmr_release_iv: got %0d expected 0", iv); else passed++;
  endtask

  initial begin
    test_reset();
    test_priority_fill();
    cc_if = 7'h7e;
    test_enable_drop();
    test_int0();
    test_clr0();
    test_clr_both();
    test_read_drain();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
